// File: rtl/traffic_sink.sv
// traffic_sink: terminal NoC sink. Accepts every flit, returns one registered
// credit per flit, tracks per-VC packet framing and counts completed packets
// against an expected total loaded by init.
module traffic_sink #(
    parameter int NUM_VC   = 4,
    parameter int VC_BITS  = 2,
    parameter int DST_BITS = 14,
    parameter int MY_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flit_valid,
    input  logic                flit_head,
    input  logic                flit_tail,
    input  logic [VC_BITS-1:0]  flit_vc,
    input  logic [DST_BITS-1:0] flit_dst,
    input  logic                init,
    input  logic [9:0]          expected_pkts,
    output logic                credit_valid,
    output logic [VC_BITS-1:0]  credit_vc,
    output logic [9:0]          pkts_rcvd,
    output logic [9:0]          last_len,
    output logic                err_frame,
    output logic                err_dst,
    output logic                done
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} vc_state_e;

    vc_state_e          state_q [NUM_VC];
    vc_state_e          state_d [NUM_VC];
    logic [9:0]         cnt_q   [NUM_VC];
    logic [9:0]         cnt_d   [NUM_VC];
    logic [9:0]         pkts_q, pkts_d;
    logic [9:0]         last_len_q, last_len_d;
    logic [9:0]         exp_q, exp_d;
    logic               err_frame_q, err_frame_d;
    logic               err_dst_q, err_dst_d;
    logic               credit_valid_q, credit_valid_d;
    logic [VC_BITS-1:0] credit_vc_q, credit_vc_d;
    logic               all_idle;

    function automatic logic [9:0] sat_inc(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    // State register: rst wins over init and any flit (no credit for it).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pkts_q         <= '0;
            last_len_q     <= '0;
            exp_q          <= '0;
            err_frame_q    <= 1'b0;
            err_dst_q      <= 1'b0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pkts_q         <= pkts_d;
            last_len_q     <= last_len_d;
            exp_q          <= exp_d;
            err_frame_q    <= err_frame_d;
            err_dst_q      <= err_dst_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
        end
    end

    // Next-state: credit echo, per-VC framing FSM, packet counting, init clear.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pkts_d         = pkts_q;
        last_len_d     = last_len_q;
        exp_d          = exp_q;
        err_frame_d    = err_frame_q;
        err_dst_d      = err_dst_q;
        // Every flit earns a credit, even one that arrives with init.
        credit_valid_d = flit_valid;
        credit_vc_d    = flit_valid ? flit_vc : credit_vc_q;

        if (init) begin
            exp_d       = expected_pkts;
            pkts_d      = '0;
            last_len_d  = '0;
            err_frame_d = 1'b0;
            err_dst_d   = 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end
        end else if (flit_valid && (int'(flit_vc) < NUM_VC)) begin
            if (flit_head) begin
                if (flit_dst != DST_BITS'(MY_ADDR)) err_dst_d = 1'b1;
                // A head on a busy VC abandons the open packet uncounted.
                if (state_q[flit_vc] == BUSY) err_frame_d = 1'b1;
                if (flit_tail) begin
                    state_d[flit_vc] = IDLE;
                    cnt_d[flit_vc]   = '0;
                    pkts_d           = sat_inc(pkts_q);
                    last_len_d       = 10'd1;
                end else begin
                    state_d[flit_vc] = BUSY;
                    cnt_d[flit_vc]   = 10'd1;
                end
            end else if (state_q[flit_vc] == IDLE) begin
                // Body/tail with no open packet: flag and drop.
                err_frame_d = 1'b1;
            end else if (flit_tail) begin
                state_d[flit_vc] = IDLE;
                cnt_d[flit_vc]   = '0;
                pkts_d           = sat_inc(pkts_q);
                last_len_d       = sat_inc(cnt_q[flit_vc]);
            end else begin
                cnt_d[flit_vc] = sat_inc(cnt_q[flit_vc]);
            end
        end
    end

    // Outputs: straight from registers; done also needs every VC idle.
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (state_q[i] != IDLE) all_idle = 1'b0;
        end
        done         = (pkts_q >= exp_q) && all_idle;
        credit_valid = credit_valid_q;
        credit_vc    = credit_vc_q;
        pkts_rcvd    = pkts_q;
        last_len     = last_len_q;
        err_frame    = err_frame_q;
        err_dst      = err_dst_q;
    end

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink; expected values are hand-derived.
module tb_traffic_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        flit_valid, flit_head, flit_tail;
    logic [1:0]  flit_vc;
    logic [13:0] flit_dst;
    logic        init;
    logic [9:0]  expected_pkts;
    logic        credit_valid;
    logic [1:0]  credit_vc;
    logic [9:0]  pkts_rcvd, last_len;
    logic        err_frame, err_dst, done;

    int n_cmp = 0;
    int n_err = 0;

    traffic_sink #(.NUM_VC(4), .VC_BITS(2), .DST_BITS(14), .MY_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
        .flit_vc(flit_vc), .flit_dst(flit_dst),
        .init(init), .expected_pkts(expected_pkts),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .pkts_rcvd(pkts_rcvd), .last_len(last_len),
        .err_frame(err_frame), .err_dst(err_dst), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One flit for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic h, input logic t, input logic [1:0] vc, input logic [13:0] dst);
        flit_valid = 1'b1; flit_head = h; flit_tail = t; flit_vc = vc; flit_dst = dst;
        tick();
        flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0; flit_vc = 2'd0; flit_dst = '0;
    endtask

    task automatic do_init(input logic [9:0] n);
        init = 1'b1; expected_pkts = n;
        tick();
        init = 1'b0;
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; expected_pkts = '0;
        flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0; flit_vc = '0; flit_dst = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_credit_valid", 32'(credit_valid), 0);
        chk("rst_credit_vc",    32'(credit_vc), 0);
        chk("rst_pkts",         32'(pkts_rcvd), 0);
        chk("rst_last_len",     32'(last_len), 0);
        chk("rst_errs",         32'({err_frame, err_dst}), 0);
        chk("rst_done",         32'(done), 1);

        // Single-flit packet.
        do_init(10'd1);
        chk("init1_done", 32'(done), 0);
        send(1, 1, 2'd0, 14'd0);
        chk("p1_credit_valid", 32'(credit_valid), 1);
        chk("p1_credit_vc",    32'(credit_vc), 0);
        chk("p1_pkts",         32'(pkts_rcvd), 1);
        chk("p1_last_len",     32'(last_len), 1);
        chk("p1_done",         32'(done), 1);
        chk("p1_errs",         32'({err_frame, err_dst}), 0);

        // Interleaved VC1 (3 flits) and VC2 (2 flits).
        do_init(10'd2);
        send(1, 0, 2'd1, 14'd0); chk("il_c0", 32'({credit_valid, credit_vc}), {1'b1, 2'd1});
        send(1, 0, 2'd2, 14'd0); chk("il_c1", 32'({credit_valid, credit_vc}), {1'b1, 2'd2});
        send(0, 0, 2'd1, 14'd0); chk("il_c2", 32'({credit_valid, credit_vc}), {1'b1, 2'd1});
        send(0, 1, 2'd2, 14'd0); chk("il_c3", 32'({credit_valid, credit_vc}), {1'b1, 2'd2});
        chk("il_pkts_mid", 32'(pkts_rcvd), 1);
        chk("il_len_mid",  32'(last_len), 2);
        chk("il_done_mid", 32'(done), 0);
        send(0, 1, 2'd1, 14'd0); chk("il_c4", 32'({credit_valid, credit_vc}), {1'b1, 2'd1});
        chk("il_pkts", 32'(pkts_rcvd), 2);
        chk("il_len",  32'(last_len), 3);
        chk("il_done", 32'(done), 1);
        tick();
        chk("il_no_credit", 32'(credit_valid), 0);

        // Body on idle VC3.
        send(0, 0, 2'd3, 14'd0);
        chk("orph_credit", 32'({credit_valid, credit_vc}), {1'b1, 2'd3});
        chk("orph_err",    32'(err_frame), 1);
        chk("orph_pkts",   32'(pkts_rcvd), 2);
        send(1, 1, 2'd0, 14'd0);
        chk("orph_sticky", 32'(err_frame), 1);
        chk("orph_pkts2",  32'(pkts_rcvd), 3);

        // Wrong destination still counts; init clears it.
        do_init(10'd1);
        chk("init_clr_frame", 32'(err_frame), 0);
        chk("init_clr_pkts",  32'(pkts_rcvd), 0);
        send(1, 0, 2'd1, 14'd1);
        chk("dst_err",  32'(err_dst), 1);
        chk("dst_busy_done", 32'(done), 0);
        send(0, 1, 2'd1, 14'd0);
        chk("dst_pkts", 32'(pkts_rcvd), 1);
        chk("dst_len",  32'(last_len), 2);
        chk("dst_done", 32'(done), 1);
        do_init(10'd1);
        chk("dst_clr",  32'(err_dst), 0);

        // Head on busy VC0 abandons the open packet.
        send(1, 0, 2'd0, 14'd0);
        send(0, 0, 2'd0, 14'd0);
        send(1, 1, 2'd0, 14'd0);
        chk("rehead_err",  32'(err_frame), 1);
        chk("rehead_pkts", 32'(pkts_rcvd), 1);
        chk("rehead_len",  32'(last_len), 1);
        chk("rehead_done", 32'(done), 1);

        // Init coincident with a flit: credit returned, flit not counted.
        init = 1'b1; expected_pkts = 10'd5;
        send(1, 1, 2'd2, 14'd0);
        init = 1'b0;
        chk("initflit_credit", 32'({credit_valid, credit_vc}), {1'b1, 2'd2});
        chk("initflit_pkts",   32'(pkts_rcvd), 0);
        chk("initflit_done",   32'(done), 0);

        // Flit counter saturates at 1023 on a 1032-flit packet.
        do_init(10'd0);
        send(1, 0, 2'd0, 14'd0);
        for (int i = 0; i < 1030; i++) send(0, 0, 2'd0, 14'd0);
        send(0, 1, 2'd0, 14'd0);
        chk("sat_len", 32'(last_len), 1023);

        // Packet count saturates at 1023.
        do_init(10'd1023);
        for (int i = 0; i < 1030; i++) send(1, 1, 2'd3, 14'd0);
        chk("sat_pkts", 32'(pkts_rcvd), 1023);
        chk("sat_done", 32'(done), 1);

        // Reset mid-packet on VC2 with a flit present.
        do_init(10'd1);
        send(1, 0, 2'd2, 14'd0);
        rst = 1'b1;
        send(0, 0, 2'd2, 14'd0);
        rst = 1'b0;
        chk("mrst_credit", 32'({credit_valid, credit_vc}), 0);
        chk("mrst_pkts",   32'(pkts_rcvd), 0);
        chk("mrst_len",    32'(last_len), 0);
        chk("mrst_errs",   32'({err_frame, err_dst}), 0);
        chk("mrst_done",   32'(done), 1);
        send(0, 1, 2'd2, 14'd0);
        chk("mrst_vc2_idle", 32'(err_frame), 1);
        chk("mrst_vc2_pkts", 32'(pkts_rcvd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_sink.md
TRAFFIC_SINK -- requirements
Module: traffic_sink

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, number of virtual channels.
REQ-002 SHALL have parameter VC_BITS, default 2, width of VC index.
REQ-003 SHALL have parameter DST_BITS, default 14, width of destination field.
REQ-004 SHALL have parameter MY_ADDR, default 0, node address this sink owns.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flit_valid, input, 1, flit present this cycle.
REQ-008 SHALL have port flit_head, input, 1, flit is packet head.
REQ-009 SHALL have port flit_tail, input, 1, flit is packet tail.
REQ-010 SHALL have port flit_vc, input, VC_BITS, VC of flit.
REQ-011 SHALL have port flit_dst, input, DST_BITS, destination (meaningful on head only).
REQ-012 SHALL have port init, input, 1, one-cycle pulse loading expected packet total.
REQ-013 SHALL have port expected_pkts, input, 10, packets to receive; sampled on init.
REQ-014 SHALL have port credit_valid, output, 1, one-buffer credit return.
REQ-015 SHALL have port credit_vc, output, VC_BITS, VC of returned credit.
REQ-016 SHALL have port pkts_rcvd, output, 10, completed packets since init/reset.
REQ-017 SHALL have port last_len, output, 10, flit count of last completed packet.
REQ-018 SHALL have port err_frame, output, 1, sticky framing error.
REQ-019 SHALL have port err_dst, output, 1, sticky wrong-destination error.
REQ-020 SHALL have port done, output, 1, expected total received and all VCs idle.

Function
REQ-021 SHALL accept every flit with flit_valid=1; no backpressure; flow control is credit-based only.
REQ-022 SHALL, for each accepted flit, drive credit_valid=1 and credit_vc=flit_vc exactly one cycle later; registered, one credit per flit.
REQ-023 SHALL keep per-VC FSM IDLE/BUSY and per-VC 10-bit flit counter.
REQ-024 SHALL, IDLE + head + !tail: go BUSY, counter=1.
REQ-025 SHALL, IDLE + head + tail: stay IDLE, pkts_rcvd+1, last_len=1.
REQ-026 SHALL, BUSY + !head + !tail: stay BUSY, counter+1 (saturate at 1023).
REQ-027 SHALL, BUSY + !head + tail: go IDLE, pkts_rcvd+1, last_len=counter+1 (saturating).
REQ-028 SHALL, IDLE + !head (body/tail without head): set err_frame, drop flit from counting, stay IDLE.
REQ-029 SHALL, BUSY + head: set err_frame, abandon open packet uncounted, restart per REQ-024/025.
REQ-030 SHALL, on head with flit_dst != MY_ADDR: set err_dst; packet is still counted normally.
REQ-031 SHALL saturate pkts_rcvd at 1023; no wrap.
REQ-032 SHALL hold err_frame and err_dst set until rst or init.
REQ-033 SHALL drive done=1 when pkts_rcvd >= expected total and all VCs IDLE; combinational from registers.
REQ-034 SHALL, on init: load expected total, clear pkts_rcvd, last_len, errors, all VC FSMs to IDLE.
REQ-035 SHALL, on init coincident with flit_valid: ignore flit for counting/FSM, but still return its credit per REQ-022.
REQ-036 SHALL treat flits on different VCs as independent; one flit per cycle total.

Reset
REQ-037 SHALL, on rst: credit_valid=0, credit_vc=0, pkts_rcvd=0, last_len=0, err_frame=0, err_dst=0, expected total=0, all VCs IDLE, counters 0.
REQ-038 SHALL give rst priority over init and flit_valid; a flit coincident with rst returns no credit.
REQ-039 SHALL make done=1 after reset (0 expected, all IDLE).

Verification
REQ-040 Reset, init expected=1, single flit head+tail VC0 dst=MY_ADDR -> credit_valid next cycle vc=0, pkts_rcvd=1, last_len=1, done=1, no errors.
REQ-041 Init expected=2; 3-flit packet on VC1 interleaved with 2-flit packet on VC2 -> 5 credits with matching VCs, pkts_rcvd=2, done=1 only after second tail.
REQ-042 Body flit on idle VC3 -> err_frame=1, pkts_rcvd unchanged, credit still returned; stays set after later good packets.
REQ-043 Head with dst=MY_ADDR+1 -> err_dst=1, packet counted; init clears err_dst.
REQ-044 Head on VC0, body, then head+tail on VC0 -> err_frame=1, pkts_rcvd=1, last_len=1.
REQ-045 rst asserted mid-packet on VC2 with flit_valid -> no credit next cycle, all outputs at reset values, VC2 IDLE.
